// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO sequencer: op and state enums plus hilo_ctrl field positions.
package hilo_pkg;

  localparam int CTRL_W     = 4;
  localparam int CTRL_EN    = 3;
  localparam int CTRL_SGN   = 2;
  localparam int CTRL_OP_HI = 1;
  localparam int CTRL_OP_LO = 0;

  typedef enum logic [1:0] {
    MUL  = 2'b00,
    MADD = 2'b01,
    MOVE = 2'b10,
    DIV  = 2'b11
  } hilo_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } hilo_state_t;

endpackage

// File: rtl/hilo_sequencer_if.sv
// EX-stage side of the HI/LO unit: decoder field, operands, stall and the architectural HI/LO values.
interface hilo_sequencer_if
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic [CTRL_W-1:0] hilo_ctrl;
  logic              issue;
  logic              flush;
  logic              rd_hilo;
  logic [WIDTH-1:0]  rs;
  logic [WIDTH-1:0]  rt;
  logic              stall;
  logic              busy;
  logic [WIDTH-1:0]  hi;
  logic [WIDTH-1:0]  lo;

  modport master (
    output hilo_ctrl, issue, flush, rd_hilo, rs, rt,
    input  stall, busy, hi, lo
  );

  modport slave (
    input  hilo_ctrl, issue, flush, rd_hilo, rs, rt,
    output stall, busy, hi, lo
  );
endinterface

// File: rtl/hilo_divstep.sv
// One combinational restoring-division step: shift in the next dividend bit, subtract if it fits.
module hilo_divstep
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_i < div_i always holds, so the top bit of diff is a clean borrow flag
  assign shifted = {rem_i, quo_i[WIDTH-1]};
  assign diff    = shifted - {1'b0, div_i};

  always_comb begin
    if (!diff[WIDTH]) begin
      rem_o = diff[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_sequencer.sv
// Multi-cycle MULT/MADD/DIV/MTx unit owning HI/LO; iterative shift-add multiply unless
// HILO_FAST_MULT_EN is defined, which forms the product in one cycle with a hardware multiplier.
module hilo_sequencer
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  hilo_sequencer_if.slave bus
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic en);
    return en ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic [2*WIDTH-1:0] x, input logic en);
    return en ? (~x + 1'b1) : x;
  endfunction

  hilo_state_t          state_q;
  logic [CW-1:0]        cnt_q;
  logic                 busy_q;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic                 is_div_q, acc_q, neg_q, rneg_q;

  // Datapath: prod_q holds the running product, or {remainder, quotient} during a divide
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     opa_q, opa_d;

  hilo_op_t             op;
  logic                 sgn, accept, rt_zero;
  logic signed [WIDTH-1:0] rs_s, rt_s;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH-1:0]     div_rem, div_quo;
  logic [2*WIDTH-1:0]   prod_fix, hilo_sum;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  assign op      = hilo_op_t'(bus.hilo_ctrl[CTRL_OP_HI:CTRL_OP_LO]);
  assign sgn     = bus.hilo_ctrl[CTRL_SGN];
  assign accept  = bus.hilo_ctrl[CTRL_EN] & bus.issue & ~bus.flush & (state_q == IDLE);
  assign rt_zero = (bus.rt == '0);
  assign rs_s    = signed'(bus.rs);
  assign rt_s    = signed'(bus.rt);
  assign mag_a   = magnitude(bus.rs, sgn);
  assign mag_b   = magnitude(bus.rt, sgn);

  hilo_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem_i (prod_q[2*WIDTH-1:WIDTH]),
    .quo_i (prod_q[WIDTH-1:0]),
    .div_i (opa_q),
    .rem_o (div_rem),
    .quo_o (div_quo)
  );

`ifndef HILO_FAST_MULT_EN
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opa_q} : '0);
`endif

  always_comb begin
    prod_d = prod_q;
    opa_d  = opa_q;
    if (accept && (op == MUL || op == MADD)) begin
`ifdef HILO_FAST_MULT_EN
      prod_d = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`else
      prod_d = {{WIDTH{1'b0}}, mag_b};
      opa_d  = mag_a;
`endif
    end else if (accept && op == DIV && !rt_zero) begin
      prod_d = {{WIDTH{1'b0}}, mag_a};
      opa_d  = mag_b;
    end else if (state_q == ITER) begin
      if (is_div_q)
        prod_d = {div_rem, div_quo};
`ifndef HILO_FAST_MULT_EN
      else
        prod_d = {mul_sum, prod_q[WIDTH-1:1]};
`endif
    end
  end

  always_ff @(posedge clk) begin
    prod_q <= prod_d;
    opa_q  <= opa_d;
  end

  // Sign correction and accumulation, consumed only in FIX
  assign prod_fix = cond_neg_wide(prod_q, neg_q);
  assign hilo_sum = {hi_q, lo_q} + prod_fix;
  assign quo_fix  = cond_neg(prod_q[WIDTH-1:0], neg_q);
  assign rem_fix  = cond_neg(prod_q[2*WIDTH-1:WIDTH], rneg_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      acc_q    <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            case (op)
              MOVE: begin
                if (sgn) hi_q <= bus.rs;
                else     lo_q <= bus.rs;
              end
              DIV: begin
                if (rt_zero) begin
                  hi_q <= bus.rs;
                  lo_q <= '1;
                end else begin
                  is_div_q <= 1'b1;
                  acc_q    <= 1'b0;
                  neg_q    <= sgn & ((rs_s < 0) ^ (rt_s < 0));
                  rneg_q   <= sgn & (rs_s < 0);
                  cnt_q    <= CNT_LAST;
                  busy_q   <= 1'b1;
                  state_q  <= ITER;
                end
              end
              default: begin
                is_div_q <= 1'b0;
                acc_q    <= (op == MADD);
                neg_q    <= sgn & ((rs_s < 0) ^ (rt_s < 0));
                rneg_q   <= 1'b0;
                cnt_q    <= CNT_LAST;
                busy_q   <= 1'b1;
`ifdef HILO_FAST_MULT_EN
                state_q  <= FIX;
`else
                state_q  <= ITER;
`endif
              end
            endcase
          end
        end
        ITER: begin
          if (cnt_q == '0) state_q <= FIX;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        FIX: begin
          if (is_div_q) begin
            lo_q <= quo_fix;
            hi_q <= rem_fix;
          end else if (acc_q) begin
            {hi_q, lo_q} <= hilo_sum;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.stall = busy_q & (bus.rd_hilo | (bus.hilo_ctrl[CTRL_EN] & bus.issue));

endmodule

// File: tb/tb_hilo_sequencer.sv
// Directed bench for hilo_sequencer: vector table of HI/LO ops plus stall, flush and reset sequences.
module tb_hilo_sequencer;

  localparam int W  = 32;
  localparam int DB = W + 1;
`ifdef HILO_FAST_MULT_EN
  localparam int MB = 1;
`else
  localparam int MB = W + 1;
`endif

  localparam logic [3:0] C_MULT  = 4'hC;
  localparam logic [3:0] C_MULTU = 4'h8;
  localparam logic [3:0] C_MADD  = 4'hD;
  localparam logic [3:0] C_MADDU = 4'h9;
  localparam logic [3:0] C_MTHI  = 4'hE;
  localparam logic [3:0] C_MTLO  = 4'hA;
  localparam logic [3:0] C_DIV   = 4'hF;
  localparam logic [3:0] C_DIVU  = 4'hB;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    int          busy;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  vec_t vecs [12];

  hilo_sequencer_if #(.WIDTH(W)) bus ();

  hilo_sequencer #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic clear_inputs();
    bus.hilo_ctrl = '0;
    bus.issue     = 1'b0;
    bus.flush     = 1'b0;
    bus.rd_hilo   = 1'b0;
    bus.rs        = '0;
    bus.rt        = '0;
  endtask

  // Issue one op for one cycle and count the cycles busy stays high afterwards
  task automatic issue_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
    @(negedge clk);
    bus.hilo_ctrl = c;
    bus.issue     = 1'b1;
    bus.rs        = a;
    bus.rt        = b;
    @(negedge clk);
    bus.hilo_ctrl = '0;
    bus.issue     = 1'b0;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    int cyc;

    vecs[0]  = '{C_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        DB};
    vecs[1]  = '{C_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, DB};
    vecs[2]  = '{C_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 0};
    vecs[3]  = '{C_MTHI,  32'h1,         32'h0,         32'h1,         32'hFFFF_FFFF, 0};
    vecs[4]  = '{C_MTLO,  32'hFFFF_FFFF, 32'h0,         32'h1,         32'hFFFF_FFFF, 0};
    vecs[5]  = '{C_MADDU, 32'h1,         32'h1,         32'h2,         32'h0,         MB};
    vecs[6]  = '{C_MULT,  32'hFFFF_FFFD, 32'h4,         32'hFFFF_FFFF, 32'hFFFF_FFF4, MB};
    vecs[7]  = '{C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MB};
    vecs[8]  = '{C_MADD,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0002, MB};
    vecs[9]  = '{C_DIV,   32'd7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD, DB};
    vecs[10] = '{C_DIVU,  32'hFFFF_FFFF, 32'h10,        32'hF,         32'h0FFF_FFFF, DB};
    vecs[11] = '{C_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, MB};

    clear_inputs();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_busy",  32'(bus.busy),  32'h0);
    check("reset_stall", 32'(bus.stall), 32'h0);
    check("reset_hi",    bus.hi,         32'h0);
    check("reset_lo",    bus.lo,         32'h0);

    for (int i = 0; i < 12; i++) begin
      issue_op(vecs[i].ctrl, vecs[i].rs, vecs[i].rt, cyc);
      check($sformatf("vec%0d_busy_cycles", i), cyc, vecs[i].busy);
      check($sformatf("vec%0d_hi", i), bus.hi, vecs[i].hi);
      check($sformatf("vec%0d_lo", i), bus.lo, vecs[i].lo);
    end

    // DIV followed by MFLO in the next slot: stall holds until the quotient lands
    @(negedge clk);
    bus.hilo_ctrl = C_DIV;
    bus.issue     = 1'b1;
    bus.rs        = 32'hFFFF_FFF9;
    bus.rt        = 32'd2;
    @(negedge clk);
    bus.hilo_ctrl = '0;
    bus.rd_hilo   = 1'b1;
    #1;
    cyc = 0;
    while (bus.stall === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    check("mflo_stall_cycles", cyc, DB);
    check("mflo_lo", bus.lo, 32'hFFFF_FFFD);
    check("mflo_hi", bus.hi, 32'hFFFF_FFFF);
    clear_inputs();

    // An op presented while busy is held, then accepted once the unit is idle
    @(negedge clk);
    bus.hilo_ctrl = C_MULTU;
    bus.issue     = 1'b1;
    bus.rs        = 32'd3;
    bus.rt        = 32'd5;
    @(negedge clk);
    bus.hilo_ctrl = C_MTLO;
    bus.rs        = 32'h55;
    #1;
    check("held_stall", 32'(bus.stall), 32'h1);
    cyc = 0;
    while (bus.stall === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    check("held_stall_cycles", cyc, MB);
    @(negedge clk);
    clear_inputs();
    check("held_hi", bus.hi, 32'h0);
    check("held_lo", bus.lo, 32'h55);

    // Flush during the iteration is ignored
    @(negedge clk);
    bus.hilo_ctrl = C_MULTU;
    bus.issue     = 1'b1;
    bus.rs        = 32'd6;
    bus.rt        = 32'd7;
    @(negedge clk);
    bus.hilo_ctrl = '0;
    bus.issue     = 1'b0;
    bus.flush     = 1'b1;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    bus.flush = 1'b0;
    check("flush_iter_busy_cycles", cyc, MB);
    check("flush_iter_hi", bus.hi, 32'h0);
    check("flush_iter_lo", bus.lo, 32'd42);

    // Flush on the issue cycle discards the op
    @(negedge clk);
    bus.hilo_ctrl = C_DIVU;
    bus.issue     = 1'b1;
    bus.flush     = 1'b1;
    bus.rs        = 32'd9;
    bus.rt        = 32'd3;
    @(negedge clk);
    clear_inputs();
    check("flush_issue_busy", 32'(bus.busy), 32'h0);
    repeat (2) @(negedge clk);
    check("flush_issue_hi", bus.hi, 32'h0);
    check("flush_issue_lo", bus.lo, 32'd42);

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    bus.hilo_ctrl = C_DIVU;
    bus.issue     = 1'b1;
    bus.rs        = 32'd100;
    bus.rt        = 32'd7;
    @(negedge clk);
    clear_inputs();
    repeat (10) @(negedge clk);
    check("midop_busy_before", 32'(bus.busy), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("midop_reset_busy", 32'(bus.busy), 32'h0);
    check("midop_reset_hi",   bus.hi,        32'h0);
    check("midop_reset_lo",   bus.lo,        32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    issue_op(C_DIVU, 32'd100, 32'd7, cyc);
    check("post_reset_busy_cycles", cyc, DB);
    check("post_reset_hi", bus.hi, 32'd2);
    check("post_reset_lo", bus.lo, 32'd14);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
